sprite_mover: RTL and testbench

Parametrised successor to the single-sprite mover. It moves one square sprite per frame_clk tick under WASD keyboard control. It adds a configurable step and size, selectable wall behaviour (bounce, wrap or stop), pause, reversal lockout and a collision flag. The block sits between the USB keycode path and the colour mapper. It supplies the sprite centre and half-size each frame.

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_axis_step.sv | 65 ++++++
 rtl/sprite_mover.sv | 149 ++++++++++++++
 tb/tb_sprite_mover.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the keyboard-driven sprite mover.
package sprite_pkg;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    typedef enum logic [1:0] {IDLE, MOVING, PAUSED, HIT} state_t;

    // USB HID keycodes recognised by the mover
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_P     = 8'h13;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Wall behaviour selectors
    localparam int WALL_BOUNCE = 0;
    localparam int WALL_WRAP   = 1;
    localparam int WALL_STOP   = 2;

    // Encoding pairs UP/DOWN and LEFT/RIGHT on bit 0, so flipping it reverses.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// Single-axis step and wall resolver: advances a centre coordinate by STEP
// and applies the selected wall behaviour to the candidate position.
module sprite_axis_step
    import sprite_pkg::*;
#(
    parameter int STEP      = 1,
    parameter int SIZE      = 4,
    parameter int MIN       = 0,
    parameter int MAX       = 639,
    parameter int WALL_MODE = 0
) (
    input  logic [9:0] pos,
    input  logic       move,
    input  logic       neg,
    output logic [9:0] next_pos,
    output logic       reverse,
    output logic       hit
);

    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] SIZE_S = 11'(SIZE);
    localparam logic signed [10:0] MIN_S  = 11'(MIN);
    localparam logic signed [10:0] MAX_S  = 11'(MAX);

    logic signed [10:0] cand;
    logic signed [10:0] lo_edge;
    logic signed [10:0] hi_edge;

    // Candidate position and wall resolution. Signed 11-bit math keeps a
    // step below column 0 negative instead of wrapping to a large value.
    // Wrap fires only once the edge crosses the limit; bounce and stop fire
    // as soon as the edge reaches it, so a bouncing sprite never idles a
    // frame against the wall.
    always_comb begin
        cand = signed'({1'b0, pos});
        if (move) begin
            cand = neg ? (cand - STEP_S) : (cand + STEP_S);
        end
        lo_edge  = cand - SIZE_S;
        hi_edge  = cand + SIZE_S;
        next_pos = cand[9:0];
        reverse  = 1'b0;
        hit      = 1'b0;
        if (move) begin
            if (WALL_MODE == WALL_WRAP) begin
                if (neg && (lo_edge < MIN_S)) begin
                    next_pos = 10'(MAX - SIZE);
                end else if (!neg && (hi_edge > MAX_S)) begin
                    next_pos = 10'(MIN + SIZE);
                end
            end else begin
                if (neg && (lo_edge <= MIN_S)) begin
                    next_pos = 10'(MIN + SIZE);
                    reverse  = (WALL_MODE == WALL_BOUNCE);
                    hit      = (WALL_MODE == WALL_STOP);
                end else if (!neg && (hi_edge >= MAX_S)) begin
                    next_pos = 10'(MAX - SIZE);
                    reverse  = (WALL_MODE == WALL_BOUNCE);
                    hit      = (WALL_MODE == WALL_STOP);
                end
            end
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// Moves one square sprite per frame under WASD control with pause, restart,
// reversal lockout and configurable wall behaviour.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 639,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 479,
    parameter int X_START    = 320,
    parameter int Y_START    = 240,
    parameter int SIZE       = 4,
    parameter int STEP       = 1,
    parameter int WALL_MODE  = 0,
    parameter int NO_REVERSE = 1
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [9:0] Size,
    output dir_t       Dir,
    output logic       Moving,
    output logic       Paused,
    output logic       Hit,
    output logic       Hit_pulse
);

    // Index 0 is the X axis, index 1 the Y axis.
    localparam logic [1:0][9:0] POS_START = {10'(Y_START), 10'(X_START)};

    state_t          state_reg, state_next;
    dir_t            dir_reg, dir_next, dir_res, key_dir;
    logic [1:0][9:0] pos_reg, pos_next, step_pos;
    logic [7:0]      prev_key_reg;
    logic            hit_pulse_reg, hit_pulse_next;
    logic            key_is_dir, p_edge, pause_toggle, restart, do_step;
    logic [1:0]      axis_move, axis_neg, axis_rev, axis_hit;

    // State, position, direction and key-history registers
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= IDLE;
            dir_reg       <= RIGHT;
            pos_reg       <= POS_START;
            prev_key_reg  <= 8'h00;
            hit_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dir_reg       <= dir_next;
            pos_reg       <= pos_next;
            prev_key_reg  <= keycode;
            hit_pulse_reg <= hit_pulse_next;
        end
    end

    // Decode direction keys; other keycodes leave key_is_dir low
    always_comb begin
        key_is_dir = 1'b1;
        key_dir    = RIGHT;
        case (keycode)
            KEY_A:   key_dir = LEFT;
            KEY_D:   key_dir = RIGHT;
            KEY_W:   key_dir = UP;
            KEY_S:   key_dir = DOWN;
            default: key_is_dir = 1'b0;
        endcase
    end

    // Resolve this frame's key into a direction and a step request;
    // pause beats a direction key pressed in the same frame
    always_comb begin
        p_edge       = (keycode == KEY_P) && (prev_key_reg != KEY_P);
        pause_toggle = p_edge && ((state_reg == MOVING) || (state_reg == PAUSED));
        restart      = (state_reg == HIT) && (keycode == KEY_ENTER);
        do_step      = ((state_reg == IDLE) && key_is_dir) ||
                       ((state_reg == MOVING) && !p_edge);
        dir_res      = dir_reg;
        if (key_is_dir) begin
            if (state_reg == IDLE) begin
                dir_res = key_dir;
            end else if ((state_reg == MOVING) && !p_edge &&
                         !((NO_REVERSE != 0) && (key_dir == opposite(dir_reg)))) begin
                dir_res = key_dir;
            end
        end
        axis_move[0] = do_step && ((dir_res == LEFT) || (dir_res == RIGHT));
        axis_neg[0]  = (dir_res == LEFT);
        axis_move[1] = do_step && ((dir_res == UP) || (dir_res == DOWN));
        axis_neg[1]  = (dir_res == UP);
    end

    // One resolver per axis; only the axis of the resolved direction moves
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        sprite_axis_step #(
            .STEP      (STEP),
            .SIZE      (SIZE),
            .MIN       ((gi == 0) ? X_MIN : Y_MIN),
            .MAX       ((gi == 0) ? X_MAX : Y_MAX),
            .WALL_MODE (WALL_MODE)
        ) u_step (
            .pos      (pos_reg[gi]),
            .move     (axis_move[gi]),
            .neg      (axis_neg[gi]),
            .next_pos (step_pos[gi]),
            .reverse  (axis_rev[gi]),
            .hit      (axis_hit[gi])
        );
    end

    // Next state, position and direction, including wall outcomes
    always_comb begin
        state_next     = state_reg;
        dir_next       = dir_res;
        pos_next       = pos_reg;
        hit_pulse_next = 1'b0;
        if (restart) begin
            state_next = IDLE;
            dir_next   = RIGHT;
            pos_next   = POS_START;
        end else if (pause_toggle) begin
            state_next = (state_reg == MOVING) ? PAUSED : MOVING;
        end else if (do_step) begin
            state_next = MOVING;
            pos_next   = step_pos;
            if (|axis_rev) begin
                dir_next = opposite(dir_res);
            end
            if (|axis_hit) begin
                state_next     = HIT;
                hit_pulse_next = 1'b1;
            end
        end
    end

    // Status outputs derived from the registered state
    always_comb begin
        PosX      = pos_reg[0];
        PosY      = pos_reg[1];
        Size      = 10'(SIZE);
        Dir       = dir_reg;
        Moving    = (state_reg == MOVING);
        Paused    = (state_reg == PAUSED);
        Hit       = (state_reg == HIT);
        Hit_pulse = hit_pulse_reg;
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: one instance per wall mode, driven by a
// shared keycode/reset, with a vector table plus hand-written wall sequences.
module tb_sprite_mover;
    import sprite_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key;

    logic [9:0] bx, by, bs, sx, sy, ss, wx, wy, ws;
    dir_t       bd, sd, wd;
    logic       bm, bp, bh, bhp;
    logic       sm, sp, sh, shp;
    logic       wm, wp, wh, whp;

    int compares = 0;
    int mismatches = 0;

    always #5 clk = ~clk;

    sprite_mover #(.WALL_MODE(WALL_BOUNCE)) u_bounce (
        .frame_clk(clk), .Reset_n(rst_n), .keycode(key),
        .PosX(bx), .PosY(by), .Size(bs), .Dir(bd),
        .Moving(bm), .Paused(bp), .Hit(bh), .Hit_pulse(bhp)
    );

    sprite_mover #(.WALL_MODE(WALL_STOP)) u_stop (
        .frame_clk(clk), .Reset_n(rst_n), .keycode(key),
        .PosX(sx), .PosY(sy), .Size(ss), .Dir(sd),
        .Moving(sm), .Paused(sp), .Hit(sh), .Hit_pulse(shp)
    );

    sprite_mover #(.WALL_MODE(WALL_WRAP)) u_wrap (
        .frame_clk(clk), .Reset_n(rst_n), .keycode(key),
        .PosX(wx), .PosY(wy), .Size(ws), .Dir(wd),
        .Moving(wm), .Paused(wp), .Hit(wh), .Hit_pulse(whp)
    );

    typedef struct {
        logic [7:0] k;
        int         x;
        int         y;
        dir_t       d;
        logic       moving;
        logic       paused;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input int act, input int exp);
        compares++;
        if (act != exp) begin
            mismatches++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One frame: drive the key, let one rising edge pass, sample 1 ns later
    task automatic frame(input logic [7:0] k);
        key = k;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        key   = 8'h00;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{8'h07, 321, 240, RIGHT, 1'b1, 1'b0};
        vecs[1]  = '{8'h07, 322, 240, RIGHT, 1'b1, 1'b0};
        vecs[2]  = '{8'h07, 323, 240, RIGHT, 1'b1, 1'b0};
        vecs[3]  = '{8'h04, 324, 240, RIGHT, 1'b1, 1'b0};
        vecs[4]  = '{8'h04, 325, 240, RIGHT, 1'b1, 1'b0};
        vecs[5]  = '{8'h1A, 325, 239, UP,    1'b1, 1'b0};
        vecs[6]  = '{8'h16, 325, 238, UP,    1'b1, 1'b0};
        vecs[7]  = '{8'h13, 325, 238, UP,    1'b0, 1'b1};
        vecs[8]  = '{8'h13, 325, 238, UP,    1'b0, 1'b1};
        vecs[9]  = '{8'h13, 325, 238, UP,    1'b0, 1'b1};
        vecs[10] = '{8'h13, 325, 238, UP,    1'b0, 1'b1};
        vecs[11] = '{8'h13, 325, 238, UP,    1'b0, 1'b1};
        vecs[12] = '{8'h07, 325, 238, UP,    1'b0, 1'b1};
        vecs[13] = '{8'h13, 325, 238, UP,    1'b1, 1'b0};
        vecs[14] = '{8'h00, 325, 237, UP,    1'b1, 1'b0};
        vecs[15] = '{8'h1A, 325, 236, UP,    1'b1, 1'b0};

        // Reset state
        do_reset();
        chk("reset_x", int'(bx), 320);
        chk("reset_y", int'(by), 240);
        chk("reset_dir", int'(bd), int'(RIGHT));
        chk("reset_moving", int'(bm), 0);
        chk("reset_paused", int'(bp), 0);
        chk("reset_hit", int'(bh), 0);
        chk("reset_hit_pulse", int'(bhp), 0);
        chk("size", int'(bs), 4);
        $display("reset: x=%0d y=%0d dir=%0d", bx, by, bd);

        // Table: motion, reversal lockout, pause hold/release/resume
        for (int i = 0; i < 16; i++) begin
            frame(vecs[i].k);
            $display("vec %0d: key=%02h x=%0d y=%0d dir=%0d mv=%0b pa=%0b",
                     i, vecs[i].k, bx, by, bd, bm, bp);
            chk($sformatf("vec%0d_x", i), int'(bx), vecs[i].x);
            chk($sformatf("vec%0d_y", i), int'(by), vecs[i].y);
            chk($sformatf("vec%0d_dir", i), int'(bd), int'(vecs[i].d));
            chk($sformatf("vec%0d_moving", i), int'(bm), int'(vecs[i].moving));
            chk($sformatf("vec%0d_paused", i), int'(bp), int'(vecs[i].paused));
        end

        // Bounce on the right wall
        do_reset();
        for (int i = 0; i < 314; i++) frame(8'h07);
        chk("bounce_pre_x", int'(bx), 634);
        frame(8'h00);
        $display("bounce frame 315: x=%0d dir=%0d", bx, bd);
        chk("bounce_315_x", int'(bx), 635);
        chk("bounce_315_dir", int'(bd), int'(LEFT));
        frame(8'h00);
        $display("bounce frame 316: x=%0d dir=%0d", bx, bd);
        chk("bounce_316_x", int'(bx), 634);
        chk("bounce_316_hit", int'(bh), 0);

        // Stop against the top wall, then restart
        do_reset();
        frame(8'h28);
        chk("enter_idle_ignored_x", int'(sx), 320);
        chk("enter_idle_ignored_mv", int'(sm), 0);
        for (int i = 0; i < 235; i++) frame(8'h1A);
        chk("stop_pre_y", int'(sy), 5);
        chk("stop_pre_hit", int'(sh), 0);
        frame(8'h1A);
        $display("stop hit frame: y=%0d hit=%0b pulse=%0b", sy, sh, shp);
        chk("stop_y", int'(sy), 4);
        chk("stop_hit", int'(sh), 1);
        chk("stop_pulse", int'(shp), 1);
        frame(8'h1A);
        $display("stop after: y=%0d hit=%0b pulse=%0b", sy, sh, shp);
        chk("stop_hold_y", int'(sy), 4);
        chk("stop_hold_hit", int'(sh), 1);
        chk("stop_hold_pulse", int'(shp), 0);
        chk("stop_hold_moving", int'(sm), 0);
        frame(8'h28);
        $display("restart: x=%0d y=%0d hit=%0b", sx, sy, sh);
        chk("restart_x", int'(sx), 320);
        chk("restart_y", int'(sy), 240);
        chk("restart_hit", int'(sh), 0);
        chk("restart_moving", int'(sm), 0);
        chk("restart_dir", int'(sd), int'(RIGHT));

        // Wrap past the left wall
        do_reset();
        for (int i = 0; i < 316; i++) frame(8'h04);
        chk("wrap_pre_x", int'(wx), 4);
        frame(8'h00);
        $display("wrap: x=%0d dir=%0d", wx, wd);
        chk("wrap_x", int'(wx), 635);
        chk("wrap_dir", int'(wd), int'(LEFT));
        frame(8'h00);
        chk("wrap_next_x", int'(wx), 634);

        // Asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 3; i++) frame(8'h07);
        chk("async_pre_x", int'(bx), 323);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: x=%0d mv=%0b dir=%0d", bx, bm, bd);
        chk("async_x", int'(bx), 320);
        chk("async_moving", int'(bm), 0);
        chk("async_dir", int'(bd), int'(RIGHT));
        @(posedge clk);
        #1;
        chk("async_hold_x", int'(bx), 320);
        rst_n = 1'b1;
        key   = 8'h00;
        frame(8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
